// File: rtl/stage_retire_pkg.sv
// Shared types and constants for the retire stage.
package stage_retire_pkg;

    localparam int XLEN      = 32;
    localparam int REGADDR_W = 5;

    // One retired instruction: PC, destination register and result value.
    typedef struct packed {
        logic [XLEN-1:0]      pc;
        logic [REGADDR_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } retire_entry_t;

endpackage

// File: rtl/stage_retire_queue.sv
// retire_queue: circular buffer accepting up to LANES entries and releasing
// up to WPORTS entries per cycle. Push entries arrive already compacted.
// Entry storage is deliberately left without reset.
module retire_queue
    import stage_retire_pkg::*;
#(
    parameter  int DEPTH  = 4,
    parameter  int LANES  = 2,
    parameter  int WPORTS = 2,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [CNT_W-1:0] i_push_cnt,
    input  retire_entry_t i_push [LANES],
    input  logic [CNT_W-1:0] i_pop_cnt,
    output retire_entry_t o_peek [WPORTS],
    output logic [CNT_W-1:0] o_count
);

    localparam logic [PTR_W-1:0] PTR_MASK = PTR_W'(DEPTH - 1);

    retire_entry_t    r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_widx [LANES];

    // Write slot for each compacted push entry, wrapping at DEPTH.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_widx[i] = (r_tail + PTR_W'(i)) & PTR_MASK;
        end
    end

    // Entry storage: only written, never reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (CNT_W'(i) < i_push_cnt) begin
                r_mem[w_widx[i]] <= i_push[i];
            end
        end
    end

    // Pointers and occupancy move together so push and pop can coexist.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= (r_head + PTR_W'(i_pop_cnt)) & PTR_MASK;
            r_tail  <= (r_tail + PTR_W'(i_push_cnt)) & PTR_MASK;
            r_count <= r_count + i_push_cnt - i_pop_cnt;
        end
    end

    // Oldest WPORTS entries, head first.
    always_comb begin
        for (int k = 0; k < WPORTS; k++) begin
            o_peek[k] = r_mem[(r_head + PTR_W'(k)) & PTR_MASK];
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/stage_retire.sv
// stage_retire: compacts mem-stage results into the retire queue and drains
// them onto register-file write ports. Optional feature macro:
// STAGE_RETIRE_INSTRET_EN adds the 64-bit instret retired-instruction counter.
module stage_retire
    import stage_retire_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int WPORTS = 2,
    parameter int DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [LANES-1:0]            wb_valid,
    input  logic [XLEN*LANES-1:0]       wb_pc,
    input  logic [REGADDR_W*LANES-1:0]  wb_reg,
    input  logic [XLEN*LANES-1:0]       wb_data,
    output logic                        wb_stall,
    output logic [REGADDR_W*WPORTS-1:0] wreg,
    output logic [XLEN*WPORTS-1:0]      wdata,
    output logic [WPORTS-1:0]           wen,
    output logic                        wb_busy,
    output logic [XLEN-1:0]             retire_pc
`ifdef STAGE_RETIRE_INSTRET_EN
    ,
    output logic [63:0]                 instret
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    retire_entry_t    w_push [LANES];
    retire_entry_t    w_peek [WPORTS];
    retire_entry_t    w_lane;
    logic [CNT_W-1:0] w_n_in;
    logic [CNT_W-1:0] w_push_cnt;
    logic [CNT_W-1:0] w_n_out;
    logic [CNT_W-1:0] w_count;
    logic             w_accept;
    logic [XLEN-1:0]  w_last_pc;
    logic [XLEN-1:0]  r_retire_pc;

    // Pack valid lanes densely in lane order so the oldest lands at tail.
    always_comb begin
        w_n_in = '0;
        w_lane = '0;
        for (int j = 0; j < LANES; j++) begin
            w_push[j] = '0;
        end
        for (int i = 0; i < LANES; i++) begin
            if (wb_valid[i]) begin
                w_lane.pc   = wb_pc[i*XLEN +: XLEN];
                w_lane.rd   = wb_reg[i*REGADDR_W +: REGADDR_W];
                w_lane.data = wb_data[i*XLEN +: XLEN];
                for (int j = 0; j < LANES; j++) begin
                    if (CNT_W'(j) == w_n_in) begin
                        w_push[j] = w_lane;
                    end
                end
                w_n_in = w_n_in + CNT_W'(1);
            end
        end
    end

    // Stall looks only at registered occupancy: a full group must always fit.
    assign wb_stall   = (w_count > CNT_W'(DEPTH - LANES));
    assign w_accept   = (|wb_valid) && !wb_stall;
    assign w_push_cnt = w_accept ? w_n_in : '0;
    assign w_n_out    = (w_count < CNT_W'(WPORTS)) ? w_count : CNT_W'(WPORTS);
    assign wb_busy    = (w_count != '0);

    retire_queue #(
        .DEPTH  (DEPTH),
        .LANES  (LANES),
        .WPORTS (WPORTS)
    ) u_queue (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_push_cnt (w_push_cnt),
        .i_push     (w_push),
        .i_pop_cnt  (w_n_out),
        .o_peek     (w_peek),
        .o_count    (w_count)
    );

    // Drive the draining entries; x0 destinations still drain but never write.
    always_comb begin
        wen       = '0;
        wreg      = '0;
        wdata     = '0;
        w_last_pc = '0;
        for (int k = 0; k < WPORTS; k++) begin
            if (CNT_W'(k) < w_n_out) begin
                wreg[k*REGADDR_W +: REGADDR_W] = w_peek[k].rd;
                wdata[k*XLEN +: XLEN]          = w_peek[k].data;
                wen[k]                         = (w_peek[k].rd != '0);
            end
            if (CNT_W'(k + 1) == w_n_out) begin
                w_last_pc = w_peek[k].pc;
            end
        end
    end

    // Remember the youngest PC retired this cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_retire_pc <= '0;
        end else if (w_n_out != '0) begin
            r_retire_pc <= w_last_pc;
        end
    end

    assign retire_pc = r_retire_pc;

`ifdef STAGE_RETIRE_INSTRET_EN
    logic [63:0] r_instret;

    // Retired-instruction count, x0 writers included, wrapping naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_instret <= '0;
        end else begin
            r_instret <= r_instret + 64'(w_n_out);
        end
    end

    assign instret = r_instret;
`endif

endmodule

// File: doc/stage_retire.md
STAGE_RETIRE -- requirements
Module: stage_retire

Interface
REQ-001 Parameter LANES, default 2: result lanes accepted from the mem stage per cycle (1..4).
REQ-002 Parameter WPORTS, default 2: register-file write ports drained per cycle (1..LANES).
REQ-003 Parameter DEPTH, default 4: retire-queue entries, power of two, at least LANES.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 wb_valid  in  LANES  per-lane result valid; lane 0 is the oldest instruction.
REQ-007 wb_pc  in  32*LANES  per-lane instruction PC.
REQ-008 wb_reg  in  5*LANES  per-lane destination register.
REQ-009 wb_data  in  32*LANES  per-lane result data.
REQ-010 wb_stall  out  1  mem stage holds its inputs while high.
REQ-011 wreg  out  5*WPORTS  register-file write address per port.
REQ-012 wdata  out  32*WPORTS  register-file write data per port.
REQ-013 wen  out  WPORTS  register-file write enable per port.
REQ-014 wb_busy  out  1  queue non-empty, used as a decode interlock.
REQ-015 retire_pc  out  32  PC of the youngest instruction retired in the previous cycle.

Function
REQ-016 Queue is a circular buffer with head, tail and count; count ranges 0..DEPTH.
REQ-017 wb_stall = (count > DEPTH-LANES), combinational from registered count only.
REQ-018 Group accepted on rising edge when any wb_valid is set and wb_stall is low; valid lanes are compacted in lane order into tail, tail+1, and so on.
REQ-019 Drain per cycle n_out = min(count, WPORTS); port k presents entry head+k; head and count update on the same edge.
REQ-020 Latency is exactly 1 cycle from acceptance edge to wen, when the queue was empty.
REQ-021 Simultaneous accept and drain: count_next = count + n_in - n_out; pointers wrap modulo DEPTH.
REQ-022 Entry with wb_reg = 0 occupies a slot and drains normally, but drives wen low for its port.
REQ-023 Port k is older than port k+1; the register file gives the higher port priority on address collision.
REQ-024 Ports k >= n_out drive wen=0, wreg=0, wdata=0.
REQ-025 retire_pc updates on the edge following a drain cycle with n_out > 0, to the PC of entry head+n_out-1; otherwise it holds.
REQ-026 wb_busy = (count != 0).

Reset
REQ-027 On reset_n low, immediately: count=0, head=tail=0, wen=0, wb_stall=0, wb_busy=0, retire_pc=0, instret=0; any partially queued entries are discarded.
REQ-028 Queue data storage is not reset.

Configuration
REQ-029 Macro STAGE_RETIRE_INSTRET_EN compiled in: output instret (64 bits) counts retired instructions, adding n_out per cycle, with entries where wb_reg=0 included; wraps modulo 2^64.
REQ-030 Macro absent: port instret and its counter do not exist; all other behaviour is identical.

Structure
REQ-031 Shared package holds the retire entry typedef {pc[31:0], rd[4:0], data[31:0]} and the XLEN=32 and REGADDR_W=5 constants.
REQ-032 One sub-module, retire_queue, implements the multi-push/multi-pop circular buffer; stage_retire holds compaction, port drive and counters.

Verification
REQ-033 Reset, then lane0 {pc=0x100, rd=5, data=0xDEADBEEF} -> next cycle wen[0]=1, wreg[0]=5, wdata[0]=0xDEADBEEF; the cycle after, retire_pc=0x100.
REQ-034 Defaults with 2 valid lanes every cycle and a DEPTH=4 queue -> wb_stall stays 0, throughput is 2 per cycle, instret increments by 2 per cycle.
REQ-035 WPORTS=1, LANES=2, DEPTH=4, both lanes valid every cycle -> wb_stall asserts once count=3, no entry is lost or duplicated, and retire order matches input PC order.
REQ-036 wb_reg=0 with data 0x1234 -> wen low for that port, instret still increments, and retire_pc equals the PC of that entry.
REQ-037 Two lanes both write rd=7 (lane0 data=1, lane1 data=2) -> same cycle wen[0]=wen[1]=1, and the register file ends with x7=2.
REQ-038 reset_n asserted with 3 entries queued -> wen and wb_busy drop immediately, and no writes occur after release.
